hex_display_scanner: RTL and testbench
======================================

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: ports clk and rst_n, all state updated on the rising edge of clk.
REQ-002 The module SHALL have parameter NUM_DIGITS, default 8, giving the digit count (legal 1..8).
REQ-003 The module SHALL have parameter CLK_DIV, default 50000, giving clk cycles per digit slot (legal >= 2).
REQ-004 The module SHALL have parameter BLINK_FRAMES, default 64, giving the frames per blink half-period (legal >= 1).
REQ-005 The module SHALL have parameter SEG_ACTIVE_LOW, default 1: when 1, a lit segment drives 0.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 load  input  1  single-cycle request to capture data_in.
REQ-009 data_in  input  4*NUM_DIGITS  value to display; nibble k maps to digit k, digit 0 rightmost.
REQ-010 blank_lz  input  1  enables leading-zero blanking.
REQ-011 blink_en  input  1  enables whole-display blinking.
REQ-012 seg  output  7  segment drive, bit0=a ... bit6=g, polarity per SEG_ACTIVE_LOW.
REQ-013 dig_en  output  NUM_DIGITS  one-hot active-high digit select.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each full scan.
REQ-015 pending  output  1  high while a loaded value waits for the frame boundary.

Function
REQ-016 Prescaler: counts 0..CLK_DIV-1; the terminal count is a "tick" and wraps to 0.
REQ-017 Digit index: advances by 1 on each tick and wraps from NUM_DIGITS-1 to 0.
REQ-018 frame_done: SHALL be 1 for exactly the cycle after the tick on which the index wraps to 0.
REQ-019 Shadow register: load=1 captures data_in into a shadow register and sets pending=1 in the next cycle.
REQ-020 Display update: the display register SHALL update from shadow only on a wrapping tick, then clear pending; there SHALL be no mid-frame tearing.
REQ-021 Simultaneous load and wrapping tick: the current data_in goes straight into the display register, and pending stays 0.
REQ-022 Repeated load before the boundary: the last value wins.
REQ-023 Decode: hex 0-F to segments: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (active-high form), inverted when SEG_ACTIVE_LOW=1.
REQ-024 Leading-zero blanking: when blank_lz=1, digit k is dark if nibbles NUM_DIGITS-1..k of the display register are all zero, except that digit 0 is never blanked.
REQ-025 Blink: a frame counter toggles a phase bit every BLINK_FRAMES frames; when blink_en=1 and phase=off, all segments are dark and dig_en still scans.
REQ-026 When blink_en=0, the phase SHALL be forced to on and the frame counter held at 0.
REQ-027 Output timing: seg and dig_en are registered and reflect the new index one cycle after the tick, and dig_en is always exactly one-hot.
REQ-028 Width rules: the index is clog2(NUM_DIGITS) bits (min 1), the prescaler is clog2(CLK_DIV) bits, and neither counter may overflow.

Reset
REQ-029 While rst_n=0 at a clock edge, the module SHALL clear the prescaler, index, frame counter, display register and shadow register to 0, and set the phase to on.
REQ-030 Output reset values: pending=0, frame_done=0, dig_en=one-hot digit 0, and seg=dark (7F when SEG_ACTIVE_LOW=1, 00 otherwise).
REQ-031 Reset mid-frame or with a pending load SHALL discard the pending value; the scan restarts at digit 0 on the first cycle after release.

Structure
REQ-032 Package hex_display_pkg SHALL hold the 16-entry segment table constant, the SEG_DARK constant and the segment bit-index constants.
REQ-033 A sub-module hex7seg_decoder (combinational nibble-to-segment decoder) SHALL be used, with a single instance muxed by the digit index.

Verification (NUM_DIGITS=8, CLK_DIV=4, BLINK_FRAMES=2, SEG_ACTIVE_LOW=1)
REQ-034 Reset release, load=0 -> dig_en steps 01,02,04,...,80,01 every 4 cycles; seg=40 (digit "0") on every digit; frame_done pulses every 32 cycles.
REQ-035 Load 0x1234ABCD mid-frame -> pending=1 and the old value is shown until the wrap; after the wrap, digits 0..7 show 5E,39,7C,77,66,4F,5B,06 (active-high) inverted, and pending=0.
REQ-036 blank_lz=1 with value 0x00000A05 -> digits 7..3 dark (7F), digit 2 shows A, digit 1 shows 0, digit 0 shows 5; with value 0 -> only digit 0 lit, showing 0.
REQ-037 blink_en=1 -> segments dark for 2 frames, lit for 2 frames, repeating, with dig_en scanning throughout; deasserting blink_en -> segments lit on the next digit slot.
REQ-038 Load asserted in the same cycle as the wrapping tick -> the new value is displayed from digit 0 of the next frame and pending never rises; rst_n=0 for 1 cycle with pending=1 -> pending=0, display=0, dig_en=01.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: segment bit positions,
// the dark pattern and the nibble-to-segment table (active-high form).
package hex_display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_DARK = 7'h00;

  // Index 15 is leftmost: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble-to-segment decoder, active-high output
// (bit 0 = segment a ... bit 6 = segment g).
module hex7seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed multi-digit hex display driver with frame-synchronous update,
// leading-zero blanking and whole-display blinking.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc, presc_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [FW-1:0]         fcnt, fcnt_nxt;
  logic                  phase, phase_nxt;
  logic [DW-1:0]         disp, disp_nxt;
  logic [DW-1:0]         shadow, shadow_nxt;
  logic                  pending_nxt;
  logic                  tick, wrap;
  logic                  lz_run, lz_dark;
  logic [3:0]            nib;
  logic [6:0]            dec_seg, seg_lit, seg_nxt;
  logic [NUM_DIGITS-1:0] dig_nxt;

  always_comb begin
    tick      = (presc == PW'(CLK_DIV - 1));
    wrap      = tick && (idx == IW'(NUM_DIGITS - 1));
    presc_nxt = tick ? '0 : presc + PW'(1);

    idx_nxt = idx;
    if (wrap)
      idx_nxt = '0;
    else if (tick)
      idx_nxt = idx + IW'(1);

    // A load coinciding with the wrap bypasses the shadow entirely.
    shadow_nxt  = load ? data_in : shadow;
    disp_nxt    = disp;
    pending_nxt = pending;
    if (load) begin
      pending_nxt = !wrap;
      if (wrap)
        disp_nxt = data_in;
    end else if (wrap) begin
      pending_nxt = 1'b0;
      if (pending)
        disp_nxt = shadow;
    end

    fcnt_nxt  = fcnt;
    phase_nxt = phase;
    if (!blink_en) begin
      fcnt_nxt  = '0;
      phase_nxt = 1'b1;
    end else if (wrap) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt_nxt  = '0;
        phase_nxt = !phase;
      end else begin
        fcnt_nxt = fcnt + FW'(1);
      end
    end
  end

  // Walk from the most significant digit down so lz_run tracks "all zero so far".
  always_comb begin
    lz_run  = 1'b1;
    lz_dark = 1'b0;
    nib     = 4'h0;
    dig_nxt = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (disp_nxt[4*k +: 4] == 4'h0);
      if (idx_nxt == IW'(k)) begin
        nib     = disp_nxt[4*k +: 4];
        lz_dark = lz_run && (k != 0);
      end
      dig_nxt[k] = (idx_nxt == IW'(k));
    end
  end

  hex7seg_decoder u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_lit = ((blank_lz && lz_dark) || (blink_en && !phase_nxt)) ? SEG_DARK : dec_seg;
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      fcnt       <= '0;
      phase      <= 1'b1;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      dig_en     <= NUM_DIGITS'(1);
      seg        <= SEG_ACTIVE_LOW ? ~SEG_DARK : SEG_DARK;
    end else begin
      presc      <= presc_nxt;
      idx        <= idx_nxt;
      fcnt       <= fcnt_nxt;
      phase      <= phase_nxt;
      disp       <= disp_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      frame_done <= wrap;
      dig_en     <= dig_nxt;
      seg        <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench: a time-indexed reference model predicts every cycle's
// outputs from the input history; a separate monitor compares them.
module tb_hex_display_scanner;

  localparam int ND  = 8;
  localparam int CD  = 4;
  localparam int BF  = 2;
  localparam int FRM = CD * ND;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic [7:0]  dig_en;
  logic        frame_done;
  logic        pending;

  hex_display_scanner #(
    .NUM_DIGITS     (ND),
    .CLK_DIV        (CD),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tm;
    logic [6:0]  seg;
    logic [7:0]  dig;
    logic        fd;
    logic        pend;
  } exp_t;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          t = 0;
  logic        cur_blz = 1'b0;
  logic        cur_ben = 1'b0;
  logic        ld_h[$];
  logic [31:0] d_h[$];
  logic        blz_h[$];
  logic        ben_h[$];

  // Outputs after the t-th clock edge since reset, from inputs of states 0..t-1.
  function automatic exp_t model(int tt);
    exp_t        e;
    int          digit, fs, e0, w;
    logic [31:0] disp;
    logic        on, dark;
    e.tm = 32'(tt);
    if (tt == 0) begin
      e.seg = 7'h7F; e.dig = 8'h01; e.fd = 1'b0; e.pend = 1'b0;
      return e;
    end
    digit = (tt / CD) % ND;
    e.dig = 8'(1) << digit;
    e.fd  = (tt % FRM) == 0;
    fs    = (tt / FRM) * FRM;
    disp  = '0;
    for (int u = 0; u < fs; u++)
      if (ld_h[u]) disp = d_h[u];
    e.pend = 1'b0;
    for (int u = fs; u < tt; u++)
      if (ld_h[u]) e.pend = 1'b1;
    on = 1'b1;
    if (ben_h[tt-1]) begin
      e0 = tt - 1;
      while (e0 > 0 && ben_h[e0-1]) e0--;
      w = 0;
      for (int s = e0 + 1; s <= tt; s++)
        if (s % FRM == 0) w++;
      on = ((w / BF) % 2) == 0;
    end
    dark = (blz_h[tt-1] && digit != 0 && (disp >> (4 * digit)) == 0) ||
           (ben_h[tt-1] && !on);
    e.seg = dark ? 7'h7F : ~HEX_TBL[disp[4*digit +: 4]];
    return e;
  endfunction

  task automatic step(input logic ld, input logic [31:0] d, input logic rst);
    load     = ld;
    data_in  = d;
    rst_n    = !rst;
    blank_lz = cur_blz;
    blink_en = cur_ben;
    if (!rst) begin
      ld_h.push_back(ld);
      d_h.push_back(d);
      blz_h.push_back(cur_blz);
      ben_h.push_back(cur_ben);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      ld_h.delete(); d_h.delete(); blz_h.delete(); ben_h.delete();
      t = 0;
    end else begin
      t++;
    end
    exp_q.push_back(model(t));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (seg !== e.seg) begin
          miscompares++;
          $display("FAIL seg t=%0d: got %h, expected %h", e.tm, seg, e.seg);
        end
        if (dig_en !== e.dig) begin
          miscompares++;
          $display("FAIL dig_en t=%0d: got %h, expected %h", e.tm, dig_en, e.dig);
        end
        if (frame_done !== e.fd) begin
          miscompares++;
          $display("FAIL frame_done t=%0d: got %b, expected %b", e.tm, frame_done, e.fd);
        end
        if (pending !== e.pend) begin
          miscompares++;
          $display("FAIL pending t=%0d: got %b, expected %b", e.tm, pending, e.pend);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] d;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    repeat (80) step(1'b0, 32'h0, 1'b0);

    repeat ($urandom_range(3, 20)) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h1234ABCD, 1'b0);
    repeat (90) step(1'b0, 32'h0, 1'b0);

    cur_blz = 1'b1;
    step(1'b1, 32'h00000A05, 1'b0);
    repeat (70) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    repeat (70) step(1'b0, 32'h0, 1'b0);
    cur_blz = 1'b0;

    // Loads landing exactly on the wrapping tick
    for (int i = 0; i < 3; i++) begin
      while (t % FRM != FRM - 1) step(1'b0, 32'h0, 1'b0);
      step(1'b1, $urandom(), 1'b0);
      repeat ($urandom_range(1, 10)) step(1'b0, 32'h0, 1'b0);
    end

    // Several loads inside one frame: the last one must win
    while (t % FRM != 2) step(1'b0, 32'h0, 1'b0);
    repeat (5) begin
      step(1'b1, $urandom(), 1'b0);
      step(1'b0, 32'h0, 1'b0);
    end
    repeat (40) step(1'b0, 32'h0, 1'b0);

    cur_ben = 1'b1;
    repeat (200) step(1'b0, 32'h0, 1'b0);
    cur_ben = 1'b0;
    repeat (40) step(1'b0, 32'h0, 1'b0);

    // Reset while a load is pending
    while (t % FRM != 10) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    repeat (40) step(1'b0, 32'h0, 1'b0);

    repeat (1500) begin
      if ($urandom_range(0, 99) == 0) cur_blz = !cur_blz;
      if ($urandom_range(0, 149) == 0) cur_ben = !cur_ben;
      d = $urandom();
      if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 7));
      step($urandom_range(0, 19) == 0, d, 1'b0);
    end

    load = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
